// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, mult/div occupancy,
// memory-wait stall with a sticky watchdog, and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MD_LAT   = 4,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        idex_memrd,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        ifid_md,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        mem_wait,
    output logic        pc_wr,
    output logic        ifid_wr,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_wr,
    output logic        md_start,
    output logic        md_busy,
    output logic        mem_timeout,
    output logic [15:0] stall_count
);

    localparam int unsigned MD_W    = 4;
    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STALL_W = 16;

    localparam logic [MD_W-1:0]    MD_LOAD   = MD_W'(MD_LAT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIM  = WAIT_W'(WAIT_MAX);
    localparam logic [STALL_W-1:0] STALL_SAT = '1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MDWAIT  = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [MD_W-1:0]     r_md_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_md_done;
    logic                r_lu_bubble;
    logic                r_timeout;
    logic [STALL_W-1:0]  r_stall_cnt;

    state_t              w_state_nxt;
    logic [MD_W-1:0]     w_md_cnt_nxt;
    logic [WAIT_W-1:0]   w_wait_cnt_nxt;
    logic                w_md_done_nxt;
    logic                w_lu_bubble_nxt;
    logic                w_timeout_nxt;
    logic                w_load_use;
    logic                w_pc_wr;
    logic                w_ifid_wr;
    logic                w_ifid_flush;
    logic                w_idex_flush;
    logic                w_pipe_wr;
    logic                w_md_start;
    logic                w_md_busy;

    // Load-use hazard between the load in ID/EX and the consumer in IF/ID
    assign w_load_use = idex_memrd && (idex_rt != 5'd0) &&
                        ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    // Next-state, counter updates and pipeline control outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_md_cnt_nxt    = r_md_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_md_done_nxt   = r_md_done;
        w_lu_bubble_nxt = 1'b0;
        w_timeout_nxt   = r_timeout;
        w_pc_wr         = 1'b1;
        w_ifid_wr       = 1'b1;
        w_pipe_wr       = 1'b1;
        w_ifid_flush    = 1'b0;
        w_idex_flush    = 1'b0;
        w_md_start      = 1'b0;
        w_md_busy       = 1'b0;

        case (r_state)
            RUN, MEMWAIT: begin
                if (mem_wait) begin
                    w_pc_wr     = 1'b0;
                    w_ifid_wr   = 1'b0;
                    w_pipe_wr   = 1'b0;
                    w_state_nxt = MEMWAIT;
                    if (r_state == RUN) begin
                        w_wait_cnt_nxt = WAIT_W'(1);
                    end else if (r_wait_cnt < WAIT_LIM) begin
                        w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    // Memory ready: issue rules are identical in RUN and MEMWAIT
                    w_state_nxt = RUN;
                    if (ifid_md && !r_md_done) begin
                        w_md_start   = 1'b1;
                        w_pc_wr      = 1'b0;
                        w_ifid_wr    = 1'b0;
                        w_idex_flush = 1'b1;
                        w_state_nxt  = MDWAIT;
                        w_md_cnt_nxt = MD_LOAD;
                    end else if (w_load_use && !r_lu_bubble) begin
                        // Held hazard after its bubble is the same instance: no second bubble
                        w_pc_wr         = 1'b0;
                        w_ifid_wr       = 1'b0;
                        w_idex_flush    = 1'b1;
                        w_lu_bubble_nxt = 1'b1;
                    end else if (branch_taken || jump) begin
                        w_ifid_flush = 1'b1;
                    end
                    if (w_ifid_wr) begin
                        w_md_done_nxt = 1'b0;
                    end
                end
            end
            MDWAIT: begin
                w_pc_wr      = 1'b0;
                w_ifid_wr    = 1'b0;
                w_idex_flush = 1'b1;
                w_md_busy    = 1'b1;
                w_pipe_wr    = !mem_wait;
                if (r_md_cnt == '0) begin
                    w_md_done_nxt = 1'b1;
                    if (mem_wait) begin
                        w_state_nxt    = MEMWAIT;
                        w_wait_cnt_nxt = WAIT_W'(1);
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_md_cnt_nxt = r_md_cnt - MD_W'(1);
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase

        // Watchdog trips as the wait counter reaches its limit
        if ((w_state_nxt == MEMWAIT) && (w_wait_cnt_nxt == WAIT_LIM)) begin
            w_timeout_nxt = 1'b1;
        end
    end

    // Outputs forced low while reset is asserted
    assign pc_wr       = w_pc_wr      && !reset;
    assign ifid_wr     = w_ifid_wr    && !reset;
    assign pipe_wr     = w_pipe_wr    && !reset;
    assign ifid_flush  = w_ifid_flush && !reset;
    assign idex_flush  = w_idex_flush && !reset;
    assign md_start    = w_md_start   && !reset;
    assign md_busy     = w_md_busy    && !reset;
    assign mem_timeout = r_timeout;
    assign stall_count = r_stall_cnt;

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_md_cnt    <= '0;
            r_wait_cnt  <= '0;
            r_md_done   <= 1'b0;
            r_lu_bubble <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_md_cnt    <= w_md_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_md_done   <= w_md_done_nxt;
            r_lu_bubble <= w_lu_bubble_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!pc_wr && (r_stall_cnt != STALL_SAT)) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 4: mult/div occupancy in cycles, legal range 2..15.
REQ-002 Parameter WAIT_MAX, default 255: memory-wait watchdog limit in cycles, legal range 1..255.
REQ-003 Clock and reset are one clock domain: clk, with reset asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 idex_memrd  in  1  instruction in ID/EX is a load.
REQ-007 idex_rt  in  5  load destination register in ID/EX.
REQ-008 ifid_rs, ifid_rt  in  5 each  source registers of instruction in IF/ID.
REQ-009 ifid_uses_rt  in  1  IF/ID instruction reads rt.
REQ-010 ifid_md  in  1  IF/ID instruction is mult/div.
REQ-011 branch_taken, jump  in  1 each  control transfer resolved in ID.
REQ-012 mem_wait  in  1  data memory not ready.
REQ-013 pc_wr, ifid_wr  out  1 each  PC and IF/ID write enables.
REQ-014 ifid_flush, idex_flush  out  1 each  IF/ID flush and ID/EX bubble insert.
REQ-015 pipe_wr  out  1  common write enable for ID/EX, EX/MEM and MEM/WB.
REQ-016 md_start  out  1  one-cycle mult/div launch pulse.
REQ-017 md_busy  out  1  high while in MDWAIT.
REQ-018 mem_timeout  out  1  sticky watchdog flag.
REQ-019 stall_count  out  16  saturating count of stall cycles.

Function
REQ-020 State register SHALL hold one of RUN, MDWAIT, MEMWAIT; outputs SHALL be combinational from state, counters and current inputs; state and counters SHALL update on rising clk.
REQ-021 Load-use hazard SHALL be idex_memrd & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & idex_rt == ifid_rt)).
REQ-022 Default outputs SHALL be pc_wr=ifid_wr=pipe_wr=1, all other 1-bit outputs 0.
REQ-023 RUN priority 1: mem_wait=1 -> pc_wr=ifid_wr=pipe_wr=0; next state MEMWAIT; wait counter loaded with 1.
REQ-024 RUN priority 2: ifid_md=1 & md_done=0 -> md_start=1, pc_wr=ifid_wr=0, idex_flush=1; next state MDWAIT; md counter loaded with MD_LAT-1.
REQ-025 RUN priority 3: load-use hazard -> pc_wr=ifid_wr=0, idex_flush=1; state stays RUN; exactly one bubble per hazard instance.
REQ-026 RUN priority 4: branch_taken|jump -> ifid_flush=1, pc_wr=ifid_wr=1.
REQ-027 md_done flag SHALL set on MDWAIT exit and clear on the first RUN cycle with ifid_wr=1, so a completed mult/div issues once and is never relaunched.
REQ-028 MDWAIT: pc_wr=ifid_wr=0, idex_flush=1, md_busy=1, pipe_wr=~mem_wait; md counter SHALL decrement every cycle regardless of mem_wait; at counter 0 next state SHALL be MEMWAIT if mem_wait else RUN.
REQ-029 MEMWAIT with mem_wait=1: pc_wr=ifid_wr=pipe_wr=0; wait counter increments, saturating at WAIT_MAX; at WAIT_MAX mem_timeout SHALL set and remain set until reset.
REQ-030 MEMWAIT with mem_wait=0: outputs SHALL follow REQ-024..026 as in RUN; next state per those rules, else RUN.
REQ-031 stall_count SHALL increment by 1 on every clock with pc_wr=0 and saturate at 16'hFFFF.
REQ-032 Simultaneous load-use and branch: load-use wins, no flush that cycle.

Reset
REQ-033 While reset=1: state RUN, counters 0, md_done=0, mem_timeout=0, stall_count=0, pc_wr=ifid_wr=pipe_wr=0, all other outputs 0.
REQ-034 Reset asserted mid-MDWAIT or mid-MEMWAIT SHALL abandon the operation immediately; after release state is RUN with no md_start pulse.

Verification
REQ-035 Load idex_rt=5, ifid_rs=5 -> one cycle pc_wr=0, idex_flush=1, stall_count 0->1; same with idex_rt=0 -> no stall.
REQ-036 ifid_md=1, MD_LAT=4 -> md_start one cycle, md_busy 4 cycles, then instruction issues once, md_start never repeats.
REQ-037 mem_wait high 3 cycles in RUN -> pipe_wr=0 for 3 cycles, stall_count=3, mem_timeout=0.
REQ-038 WAIT_MAX=4, mem_wait held 10 cycles -> mem_timeout=1 from 4th MEMWAIT cycle on, stays 1 after mem_wait drops.
REQ-039 Load-use and branch_taken same cycle -> idex_flush=1, ifid_flush=0; next cycle with branch still taken -> ifid_flush=1.
REQ-040 Reset pulse during MDWAIT cycle 2 -> all outputs 0 during reset, RUN after release, stall_count=0.
